write_back: RTL

Final pipeline stage, directly downstream of execute via `i_execute_to_write.write_in`. Retires one instruction at a time: commits register and flag results into the architectural register file, performs memory stores over a wait-request memory port, and signals PC redirects back to fetch/decode. The register file it owns drives the read stage.

---
 rtl/write_back_if.sv | 24 ++
 rtl/write_back.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/write_back_if.sv
// Execute-to-write-back handoff: one instruction per accept edge, with hold
// returned upstream while a store is pending.
interface i_execute_to_write;
    logic        is_valid;
    logic        has_flushed;
    logic        is_writing_memory;
    logic [4:0]  destination_register;
    logic [31:0] destination_value;
    logic [31:0] adjustment_value;
    logic [3:0]  flags;
    logic        hold;

    modport write_out (
        output is_valid, has_flushed, is_writing_memory, destination_register,
               destination_value, adjustment_value, flags,
        input  hold
    );

    modport write_in (
        input  is_valid, has_flushed, is_writing_memory, destination_register,
               destination_value, adjustment_value, flags,
        output hold
    );
endinterface

// File: rtl/write_back.sv
// Final pipeline stage: retires instructions into the architectural register
// file, performs stores over a wait-request port and signals PC redirects.
package wb_pkg;
    localparam int unsigned NR    = 4;
    localparam int unsigned FLAGS = NR - 1;
    localparam int unsigned PC    = NR - 2;

    typedef logic [NR-1:0][31:0] regfile_t;
    localparam regfile_t ZeroRegFile = '0;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        STORING = 1'b1
    } wb_state_e;
endpackage

module write_back
    import wb_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    i_execute_to_write.write_in     from_execute,
    output regfile_t                registers,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic [31:0]             mem_address,
    output logic [31:0]             mem_data,
    output logic                    mem_write,
    input  logic                    mem_wait_request,
    output logic [31:0]             retired_count
);

    localparam logic [4:0] DEST_ZERO  = 5'd0;
    localparam logic [4:0] DEST_ONE   = 5'd1;
    localparam logic [4:0] DEST_PC    = 5'(PC);
    localparam logic [4:0] DEST_FLAGS = 5'(FLAGS);

    wb_state_e   state_q, state_d;
    regfile_t    regs_q, regs_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] retired_count_q, retired_count_d;

    logic accept;
    logic retire;

    assign from_execute.hold = (state_q == STORING);
    assign accept            = (state_q == IDLE);
    assign retire            = accept && from_execute.is_valid && !from_execute.has_flushed;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case below leaves one unassigned and infers a latch.
        state_d          = state_q;
        regs_d           = regs_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        mem_address_d    = mem_address_q;
        mem_data_d       = mem_data_q;
        mem_write_d      = mem_write_q;
        retired_count_d  = retired_count_q;

        unique case (state_q)
            IDLE: begin
                if (retire) begin
                    if (from_execute.is_writing_memory) begin
                        mem_address_d = from_execute.adjustment_value;
                        mem_data_d    = from_execute.destination_value;
                        mem_write_d   = 1'b1;
                        state_d       = STORING;
                    end else begin
                        retired_count_d = retired_count_q + 32'd1;
                        // Flags update first; a direct write to Flags overrides it.
                        regs_d[FLAGS]   = 32'(from_execute.flags);
                        unique case (from_execute.destination_register)
                            DEST_ONE:   regs_d[1]     = from_execute.destination_value;
                            DEST_PC: begin
                                regs_d[PC]       = from_execute.destination_value;
                                redirect_valid_d = 1'b1;
                                redirect_pc_d    = from_execute.destination_value;
                            end
                            DEST_FLAGS: regs_d[FLAGS] = from_execute.destination_value;
                            DEST_ZERO:  ;
                            default:    ;
                        endcase
                    end
                end
            end

            STORING: begin
                if (!mem_wait_request) begin
                    mem_write_d     = 1'b0;
                    retired_count_d = retired_count_q + 32'd1;
                    state_d         = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        regs_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q          <= IDLE;
            // NOTE: the register file is only NR flops deep and architecturally
            // defined at reset, so it is cleared like any other state register.
            regs_q           <= ZeroRegFile;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mem_address_q    <= '0;
            mem_data_q       <= '0;
            mem_write_q      <= 1'b0;
            retired_count_q  <= '0;
        end else begin
            state_q          <= state_d;
            regs_q           <= regs_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            mem_address_q    <= mem_address_d;
            mem_data_q       <= mem_data_d;
            mem_write_q      <= mem_write_d;
            retired_count_q  <= retired_count_d;
        end
    end

    assign registers      = regs_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mem_address    = mem_address_q;
    assign mem_data       = mem_data_q;
    assign mem_write      = mem_write_q;
    assign retired_count  = retired_count_q;

endmodule
